// File: rtl/gravity_drop_ctrl_pkg.sv
// gravity_drop_ctrl_pkg: shared tetris_pkg with FSM states, tick/level widths and threshold function
package tetris_pkg;
  typedef enum logic [1:0] {COUNT, REQ, CLEAR} state_t;
  localparam int SEC_W = 3;
  localparam int LEVEL_W = 3;
  localparam int TH_BASE = 4;
  function automatic int thr_sat(input int lvl, input int base);
    return (base - lvl < 1) ? 1 : base - lvl;
  endfunction
endpackage

// File: rtl/gravity_drop_ctrl_if.sv
// gravity_drop_ctrl_if: drop request/acknowledge handshake between gravity control and game FSM
interface gravity_drop_ctrl_if;
  logic drop_req;
  logic drop_ack;
  modport master(output drop_req, input drop_ack);
  modport slave(input drop_req, output drop_ack);
endinterface

// File: rtl/gravity_drop_ctrl.sv
// gravity_drop_ctrl: level-paced drop requests from timer ticks; soft drop enabled by GRAVITY_SOFT_DROP_EN
module gravity_drop_ctrl
  import tetris_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SEC_W-1:0]   sec,
  output logic               force_reset,
  input  logic [LEVEL_W-1:0] level,
  input  logic               pause,
  input  logic               soft_drop,
  gravity_drop_ctrl_if.master drop,
  output logic [CNT_W-1:0]   drop_count,
  output logic               overrun
);
  state_t state_q, state_d;
  logic [SEC_W-1:0] thr_q, thr_d, sec_q, sec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic req_q, req_d, fr_q, fr_d, ovr_q, ovr_d, skip_q, skip_d, wrap;
`ifndef GRAVITY_SOFT_DROP_EN
  logic unused_soft_drop;
  assign unused_soft_drop = soft_drop;
`endif
  always_comb begin
`ifdef GRAVITY_SOFT_DROP_EN
    thr_d = soft_drop ? SEC_W'(1) : SEC_W'(thr_sat(int'(level), TH_BASE));
`else
    thr_d = SEC_W'(thr_sat(int'(level), TH_BASE));
`endif
    // a backwards step in sec is a missed wrap unless the timer was just zeroed by us
    wrap = state_q == COUNT && !pause && !skip_q && sec < sec_q;
    state_d = state_q == COUNT ? ((!pause && (sec >= thr_q || wrap)) ? REQ : COUNT)
            : state_q == REQ   ? (drop.drop_ack ? CLEAR : REQ)
            : COUNT;
    skip_d = state_q == CLEAR || (state_q == COUNT && pause);
    cnt_d = cnt_q + CNT_W'(state_q == REQ && drop.drop_ack);
    req_d = state_d == REQ;
    fr_d = state_d == CLEAR || (state_d == COUNT && pause);
    ovr_d = wrap;
    sec_d = sec;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COUNT;
      thr_q <= SEC_W'(TH_BASE);
      sec_q <= '0;
      cnt_q <= '0;
      req_q <= 1'b0;
      fr_q <= 1'b1;
      ovr_q <= 1'b0;
      skip_q <= 1'b1;
    end else begin
      state_q <= state_d;
      thr_q <= thr_d;
      sec_q <= sec_d;
      cnt_q <= cnt_d;
      req_q <= req_d;
      fr_q <= fr_d;
      ovr_q <= ovr_d;
      skip_q <= skip_d;
    end
  end
  assign drop.drop_req = req_q;
  assign force_reset = fr_q;
  assign drop_count = cnt_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_gravity_drop_ctrl.sv
// tb_gravity_drop_ctrl: randomized bench with a tick-timer model and a drop-timing reference model
module tb_gravity_drop_ctrl;
  logic clk = 0;
  logic rst = 1;
  logic [2:0] sec = 0;
  logic force_reset;
  logic [2:0] level = 0;
  logic pause = 0;
  logic soft_drop = 0;
  logic [15:0] drop_count;
  logic overrun;
  gravity_drop_ctrl_if dif();
  gravity_drop_ctrl dut (
    .clk(clk), .rst(rst), .sec(sec), .force_reset(force_reset), .level(level),
    .pause(pause), .soft_drop(soft_drop), .drop(dif), .drop_count(drop_count), .overrun(overrun)
  );
  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int period = 4;
  int div = 0;
  bit timer_en = 1;
  logic [15:0] exp_count = 0;

  // one clock; the timer model zeroes sec when it saw force_reset high at the edge
  task automatic step();
    logic fr;
    fr = force_reset;
    @(posedge clk);
    #1;
    if (fr) begin
      sec = 0;
      div = 0;
    end else if (timer_en) begin
      div++;
      if (div == period) begin
        div = 0;
        sec = sec + 3'd1;
      end
    end
  endtask

  function automatic int ref_thr(input int lvl);
    return (lvl >= 3) ? 1 : 4 - lvl;
  endfunction

  task automatic apply_reset();
    rst = 1;
    repeat (3) step();
    rst = 0;
    step();
    exp_count = 0;
  endtask

  // starts on the first cycle after the timer was zeroed; the request must arrive thr*period+1 cycles later
  task automatic do_drop(input int thr_e, input int d, input string tag);
    int k;
    k = 0;
    while (dif.drop_req !== 1'b1 && k < 400) begin
      step();
      k++;
    end
    tests++;
    if (k != thr_e * period + 1) begin
      fails++;
      $display("FAIL %s req_latency: got %0d cycles, expected %0d", tag, k, thr_e * period + 1);
    end
    repeat (d) step();
    tests++;
    if (dif.drop_req !== 1'b1) begin
      fails++;
      $display("FAIL %s req_held: drop_req=%b expected 1", tag, dif.drop_req);
    end
    dif.drop_ack = 1;
    step();
    dif.drop_ack = 0;
    exp_count++;
    tests++;
    if (force_reset !== 1'b1 || dif.drop_req !== 1'b0) begin
      fails++;
      $display("FAIL %s clear: force_reset=%b drop_req=%b expected 1/0", tag, force_reset, dif.drop_req);
    end
    step();
    tests++;
    if (force_reset !== 1'b0 || sec !== 3'd0 || drop_count !== exp_count || overrun !== 1'b0) begin
      fails++;
      $display("FAIL %s after_clear: force_reset=%b sec=%0d count=%0d overrun=%b expected 0/0/%0d/0",
               tag, force_reset, sec, drop_count, overrun, exp_count);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) step();
    tests++;
    if (dif.drop_req !== 1'b0 || force_reset !== 1'b1 || drop_count !== 16'd0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL reset: req=%b fr=%b count=%0d ovr=%b expected 0/1/0/0",
               dif.drop_req, force_reset, drop_count, overrun);
    end
    rst = 0;
    step();
    exp_count = 0;
    tests++;
    if (force_reset !== 1'b0 || sec !== 3'd0) begin
      fails++;
      $display("FAIL reset_release: fr=%b sec=%0d expected 0/0", force_reset, sec);
    end
  endtask

  task automatic test_level0();
    period = 4;
    level = 0;
    do_drop(4, 2, "level0");
  endtask

  task automatic test_level_sat();
    logic [15:0] start;
    start = exp_count;
    level = 5;
    for (int i = 0; i < 10; i++) do_drop(1, $urandom_range(0, 3), "level_sat");
    tests++;
    if (drop_count - start !== 16'd10) begin
      fails++;
      $display("FAIL level_sat_total: got %0d drops expected 10", drop_count - start);
    end
  endtask

  task automatic test_same_cycle();
    level = 2;
    do_drop(2, 0, "same_cycle");
  endtask

  task automatic test_pause();
    int k, bad;
    level = 0;
    k = 0;
    while (sec !== 3'd3 && k < 100) begin
      step();
      k++;
    end
    pause = 1;
    step();
    bad = 0;
    for (int i = 0; i < 4 * period + 4; i++) begin
      step();
      if (force_reset !== 1'b1 || dif.drop_req !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL pause_hold: %0d bad cycles expected 0", bad);
    end
    pause = 0;
    step();
    do_drop(4, 1, "after_pause");
  endtask

  task automatic test_overrun();
    level = 0;
    timer_en = 0;
    sec = 2;
    step();
    sec = 3;
    step();
    sec = 1;
    step();
    tests++;
    if (overrun !== 1'b1 || dif.drop_req !== 1'b1) begin
      fails++;
      $display("FAIL overrun_pulse: ovr=%b req=%b expected 1/1", overrun, dif.drop_req);
    end
    step();
    tests++;
    if (overrun !== 1'b0 || dif.drop_req !== 1'b1) begin
      fails++;
      $display("FAIL overrun_single: ovr=%b req=%b expected 0/1", overrun, dif.drop_req);
    end
    dif.drop_ack = 1;
    step();
    dif.drop_ack = 0;
    exp_count++;
    step();
    timer_en = 1;
    tests++;
    if (drop_count !== exp_count || sec !== 3'd0) begin
      fails++;
      $display("FAIL overrun_count: count=%0d sec=%0d expected %0d/0", drop_count, sec, exp_count);
    end
  endtask

  task automatic test_random();
    int lvl;
    for (int i = 0; i < 8; i++) begin
      period = $urandom_range(2, 5);
      lvl = $urandom_range(0, 7);
      level = 3'(lvl);
      do_drop(ref_thr(lvl), $urandom_range(0, 4), "random");
    end
    period = 4;
  endtask

  task automatic test_soft_drop();
    level = 0;
    soft_drop = 1;
`ifdef GRAVITY_SOFT_DROP_EN
    do_drop(1, 1, "soft_on");
`else
    do_drop(4, 1, "soft_ignored");
`endif
    soft_drop = 0;
    do_drop(4, 1, "soft_off");
  endtask

  task automatic test_withhold();
    int k, bad;
    apply_reset();
    period = 2;
    level = 0;
    k = 0;
    while (dif.drop_req !== 1'b1 && k < 400) begin
      step();
      k++;
    end
    bad = 0;
    for (int i = 0; i < 20 * period; i++) begin
      step();
      if (dif.drop_req !== 1'b1 || overrun !== 1'b0) bad++;
    end
    tests++;
    if (k != 4 * period + 1 || bad != 0) begin
      fails++;
      $display("FAIL withhold: latency=%0d bad=%0d expected %0d/0", k, bad, 4 * period + 1);
    end
    rst = 1;
    step();
    tests++;
    if (dif.drop_req !== 1'b0 || drop_count !== exp_count || force_reset !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_req: req=%b count=%0d fr=%b expected 0/%0d/1",
               dif.drop_req, drop_count, force_reset, exp_count);
    end
    rst = 0;
    step();
  endtask

  initial begin
    dif.drop_ack = 0;
    test_reset();
    test_level0();
    test_level_sat();
    test_same_cycle();
    test_pause();
    test_overrun();
    test_random();
    test_soft_drop();
    test_withhold();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
